// File: rtl/cg_stage_sequencer_if.sv
// cg_stage_sequencer_if: config write, command and per-stage core signals of the stage sequencer
interface cg_stage_sequencer_if #(parameter int NSTAGES = 4, parameter int SW = 3);
  logic I_WE;
  logic [SW-1:0] I_WADDR;
  logic I_WSEL;
  logic [23:0] I_WDATA;
  logic I_ARM;
  logic I_FIRE;
  logic I_ABORT;
  logic I_CLR;
  logic [NSTAGES-1:0] I_GATE;
  logic [NSTAGES-1:0] I_RDY;
  logic [NSTAGES-1:0] O_TRIG;
  logic [NSTAGES-1:0] O_OE;
  logic [NSTAGES*24-1:0] O_LMT;
  logic [NSTAGES*24-1:0] O_DLY;
  logic [SW-1:0] O_STAGE;
  logic O_BUSY;
  logic O_DONE;
  logic O_FAULT;
  logic [1:0] O_FCODE;
  modport master (
    output I_WE, I_WADDR, I_WSEL, I_WDATA, I_ARM, I_FIRE, I_ABORT, I_CLR, I_GATE, I_RDY,
    input O_TRIG, O_OE, O_LMT, O_DLY, O_STAGE, O_BUSY, O_DONE, O_FAULT, O_FCODE
  );
  modport slave (
    input I_WE, I_WADDR, I_WSEL, I_WDATA, I_ARM, I_FIRE, I_ABORT, I_CLR, I_GATE, I_RDY,
    output O_TRIG, O_OE, O_LMT, O_DLY, O_STAGE, O_BUSY, O_DONE, O_FAULT, O_FCODE
  );
endinterface

// File: rtl/cg_stage_sequencer.sv
// cg_stage_sequencer: fires a chain of coil stages, each triggered by the previous stage's gate edge
module cg_stage_sequencer #(
  parameter int NSTAGES = 4,
  parameter logic [23:0] TIMEOUT = 24'd1000000,
  parameter int SW = 3
) (
  input logic clk,
  input logic I_RST,
  cg_stage_sequencer_if.slave b
);
  localparam int AW = NSTAGES > 1 ? $clog2(NSTAGES) : 1;
  localparam logic [SW:0] NS = (SW+1)'(NSTAGES);
  localparam logic [SW-1:0] LAST = SW'(NSTAGES - 1);
  localparam logic [23:0] TLIM = TIMEOUT - 24'd1;
  typedef enum logic [1:0] {IDLE, ARMED, WAIT, FAULT} state_t;
  state_t state_q;
  logic [NSTAGES-1:0][23:0] lmt_q, dly_q;
  logic [NSTAGES-1:0] gate_q, trig_q, oe_q, rise, one;
  logic [SW-1:0] stage_q;
  logic [23:0] cnt_q;
  logic done_q, fault_q, hit, bad;
  logic [1:0] fcode_q;
  always_comb begin
    rise = b.I_GATE & ~gate_q;
    one = '0;
    one[stage_q[AW-1:0]] = 1'b1;
    hit = |(rise & one);
    bad = |(rise & ~one);
  end
  always_ff @(posedge clk) begin
    if (I_RST) begin
      state_q <= IDLE;
      lmt_q <= '0;
      dly_q <= '0;
      gate_q <= '0;
      trig_q <= '0;
      oe_q <= '0;
      stage_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
      fcode_q <= 2'd0;
    end else begin
      gate_q <= b.I_GATE;
      trig_q <= '0;
      done_q <= 1'b0;
      if (b.I_ABORT) begin
        state_q <= IDLE;
        oe_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (b.I_WE && {1'b0, b.I_WADDR} < NS) begin
              if (b.I_WSEL) dly_q[b.I_WADDR[AW-1:0]] <= b.I_WDATA;
              else lmt_q[b.I_WADDR[AW-1:0]] <= b.I_WDATA;
            end
            if (b.I_CLR) begin
              fault_q <= 1'b0;
              fcode_q <= 2'd0;
            end
            if (b.I_ARM && !fault_q) begin
              state_q <= ARMED;
              oe_q <= '1;
            end
          end
          ARMED: if (b.I_FIRE) begin
            if (&b.I_RDY) begin
              state_q <= WAIT;
              stage_q <= '0;
              trig_q <= NSTAGES'(1);
              cnt_q <= '0;
            end else begin
              state_q <= FAULT;
              oe_q <= '0;
              fault_q <= 1'b1;
              fcode_q <= 2'd2;
            end
          end
          WAIT: begin
            cnt_q <= cnt_q + 24'd1;
            // a stray edge outranks everything; a correct edge outranks a coincident timeout
            if (bad) begin
              state_q <= FAULT;
              oe_q <= '0;
              fault_q <= 1'b1;
              fcode_q <= 2'd3;
            end else if (hit && stage_q == LAST) begin
              state_q <= IDLE;
              oe_q <= '0;
              done_q <= 1'b1;
            end else if (hit) begin
              stage_q <= stage_q + 1'b1;
              trig_q <= one << 1;
              cnt_q <= '0;
            end else if (cnt_q == TLIM) begin
              state_q <= FAULT;
              oe_q <= '0;
              fault_q <= 1'b1;
              fcode_q <= 2'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign b.O_TRIG = trig_q;
  assign b.O_OE = oe_q;
  assign b.O_LMT = lmt_q;
  assign b.O_DLY = dly_q;
  assign b.O_STAGE = stage_q;
  assign b.O_BUSY = state_q == ARMED || state_q == WAIT;
  assign b.O_DONE = done_q;
  assign b.O_FAULT = fault_q;
  assign b.O_FCODE = fcode_q;
endmodule

// File: tb/tb_cg_stage_sequencer.sv
// tb_cg_stage_sequencer: randomized scenario bench for the 4-stage sequencer with a short timeout
module tb_cg_stage_sequencer;
  localparam int N = 4;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nchk = 0;
  int nbad = 0;
  logic [N-1:0][23:0] ml, md;
  cg_stage_sequencer_if #(.NSTAGES(N), .SW(3)) b();
  cg_stage_sequencer #(.NSTAGES(N), .TIMEOUT(24'(TO)), .SW(3)) dut (.clk(clk), .I_RST(rst), .b(b));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    nchk++;
    if ($countones(b.O_TRIG) > 1) begin nbad++; $display("FAIL trig_onehot got=%b exp=at most one bit", b.O_TRIG); end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input bit sel, input logic [23:0] d, input bit in_idle);
    b.I_WE = 1'b1; b.I_WADDR = 3'(a); b.I_WSEL = sel; b.I_WDATA = d;
    tick();
    b.I_WE = 1'b0;
    if (in_idle && a < N) begin
      if (sel) md[a] = d; else ml[a] = d;
    end
  endtask
  task automatic arm;
    b.I_ARM = 1'b1; tick(); b.I_ARM = 1'b0;
  endtask
  task automatic fire;
    b.I_FIRE = 1'b1; tick(); b.I_FIRE = 1'b0;
  endtask
  task automatic gate(input int k);
    b.I_GATE[k] = 1'b1; tick(); b.I_GATE[k] = 1'b0;
  endtask
  task automatic abort;
    b.I_ABORT = 1'b1; tick(); b.I_ABORT = 1'b0;
  endtask
  task automatic clr;
    b.I_CLR = 1'b1; tick(); b.I_CLR = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; tick(); tick();
    ml = '0; md = '0;
    nchk++;
    if ({b.O_TRIG, b.O_OE, b.O_STAGE, b.O_BUSY, b.O_DONE, b.O_FAULT, b.O_FCODE} !== '0 || b.O_LMT !== ml || b.O_DLY !== md) begin
      nbad++; $display("FAIL reset got trig=%b oe=%b stg=%0d busy=%b done=%b flt=%b fc=%0d lmt=%h exp=all zero",
        b.O_TRIG, b.O_OE, b.O_STAGE, b.O_BUSY, b.O_DONE, b.O_FAULT, b.O_FCODE, b.O_LMT);
    end
    rst = 1'b0; tick();
  endtask
  task automatic run_chain(input string n, input bit fixed_gap);
    int g;
    arm();
    nchk++;
    if (b.O_OE !== 4'hF || b.O_BUSY !== 1'b1) begin nbad++; $display("FAIL %s_armed got oe=%b busy=%b exp oe=1111 busy=1", n, b.O_OE, b.O_BUSY); end
    fire();
    nchk++;
    if (b.O_TRIG !== 4'b0001 || b.O_STAGE !== 3'd0) begin nbad++; $display("FAIL %s_trig0 got=%b stg=%0d exp=0001 stg=0", n, b.O_TRIG, b.O_STAGE); end
    for (int k = 0; k < N; k++) begin
      g = fixed_gap ? 49 : int'($urandom_range(0, 60));
      for (int c = 0; c < g; c++) tick();
      nchk++;
      if (b.O_TRIG !== 4'b0000 || b.O_FAULT !== 1'b0 || b.O_BUSY !== 1'b1) begin
        nbad++; $display("FAIL %s_gap%0d got trig=%b flt=%b busy=%b exp trig=0000 flt=0 busy=1", n, k, b.O_TRIG, b.O_FAULT, b.O_BUSY);
      end
      gate(k);
      if (k < N - 1) begin
        nchk++;
        if (b.O_TRIG !== 4'(1 << (k + 1)) || b.O_STAGE !== 3'(k + 1)) begin
          nbad++; $display("FAIL %s_trig%0d got=%b stg=%0d exp=%b stg=%0d", n, k + 1, b.O_TRIG, b.O_STAGE, 4'(1 << (k + 1)), k + 1);
        end
      end else begin
        nchk++;
        if (b.O_DONE !== 1'b1 || b.O_TRIG !== 4'b0000) begin nbad++; $display("FAIL %s_done got done=%b trig=%b exp done=1 trig=0000", n, b.O_DONE, b.O_TRIG); end
      end
    end
    tick();
    nchk++;
    if (b.O_DONE !== 1'b0 || b.O_OE !== 4'h0 || b.O_BUSY !== 1'b0 || b.O_FAULT !== 1'b0) begin
      nbad++; $display("FAIL %s_end got done=%b oe=%b busy=%b flt=%b exp 0 0000 0 0", n, b.O_DONE, b.O_OE, b.O_BUSY, b.O_FAULT);
    end
  endtask
  task automatic test_config_nominal;
    for (int k = 0; k < N; k++) begin
      wr(k, 1'b0, 24'(100 * (k + 1)), 1'b1);
      wr(k, 1'b1, 24'(10 * (k + 1)), 1'b1);
    end
    nchk++;
    if (b.O_LMT[47:24] !== 24'd200) begin nbad++; $display("FAIL nom_lmt1 got=%0d exp=200", b.O_LMT[47:24]); end
    nchk++;
    if (b.O_LMT !== ml || b.O_DLY !== md) begin nbad++; $display("FAIL nom_cfg got lmt=%h dly=%h exp lmt=%h dly=%h", b.O_LMT, b.O_DLY, ml, md); end
    run_chain("nom", 1'b1);
  endtask
  task automatic test_random_runs;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) begin
        wr(k, 1'b0, 24'($urandom), 1'b1);
        wr(k, 1'b1, 24'($urandom), 1'b1);
      end
      nchk++;
      if (b.O_LMT !== ml || b.O_DLY !== md) begin nbad++; $display("FAIL rnd_cfg%0d got lmt=%h dly=%h exp lmt=%h dly=%h", r, b.O_LMT, b.O_DLY, ml, md); end
      run_chain("rnd", 1'b0);
    end
  endtask
  task automatic test_timeout;
    int n;
    arm(); fire();
    n = 0;
    while (b.O_FAULT !== 1'b1 && n < 4 * TO) begin tick(); n++; end
    nchk++;
    if (n !== TO) begin nbad++; $display("FAIL to_latency got=%0d exp=%0d", n, TO); end
    nchk++;
    if (b.O_FCODE !== 2'd1 || b.O_OE !== 4'h0 || b.O_TRIG !== 4'h0) begin
      nbad++; $display("FAIL to_fault got fc=%0d oe=%b trig=%b exp fc=1 oe=0000 trig=0000", b.O_FCODE, b.O_OE, b.O_TRIG);
    end
    tick(); arm();
    nchk++;
    if (b.O_OE !== 4'h0 || b.O_BUSY !== 1'b0 || b.O_FAULT !== 1'b1) begin nbad++; $display("FAIL to_arm_locked got oe=%b busy=%b flt=%b exp 0000 0 1", b.O_OE, b.O_BUSY, b.O_FAULT); end
    clr();
    nchk++;
    if (b.O_FAULT !== 1'b0 || b.O_FCODE !== 2'd0) begin nbad++; $display("FAIL to_clr got flt=%b fc=%0d exp 0 0", b.O_FAULT, b.O_FCODE); end
    arm();
    nchk++;
    if (b.O_OE !== 4'hF || b.O_BUSY !== 1'b1) begin nbad++; $display("FAIL to_rearm got oe=%b busy=%b exp 1111 1", b.O_OE, b.O_BUSY); end
    abort();
  endtask
  task automatic test_timeout_tie;
    arm(); fire();
    for (int c = 0; c < TO - 1; c++) tick();
    gate(0);
    nchk++;
    if (b.O_TRIG !== 4'b0010 || b.O_FAULT !== 1'b0 || b.O_BUSY !== 1'b1) begin
      nbad++; $display("FAIL tie_edge_wins got trig=%b flt=%b busy=%b exp 0010 0 1", b.O_TRIG, b.O_FAULT, b.O_BUSY);
    end
    abort();
    nchk++;
    if (b.O_BUSY !== 1'b0 || b.O_OE !== 4'h0) begin nbad++; $display("FAIL tie_abort got busy=%b oe=%b exp 0 0000", b.O_BUSY, b.O_OE); end
  endtask
  task automatic test_not_ready;
    logic [N-1:0] r;
    for (int i = 0; i < 3; i++) begin
      r = (i == 0) ? 4'b1011 : 4'($urandom_range(0, 14));
      arm();
      b.I_RDY = r;
      fire();
      nchk++;
      if (b.O_TRIG !== 4'h0 || b.O_FAULT !== 1'b1 || b.O_FCODE !== 2'd2 || b.O_OE !== 4'h0) begin
        nbad++; $display("FAIL nrdy%0d rdy=%b got trig=%b flt=%b fc=%0d oe=%b exp 0000 1 2 0000", i, r, b.O_TRIG, b.O_FAULT, b.O_FCODE, b.O_OE);
      end
      b.I_RDY = '1;
      tick();
      nchk++;
      if (b.O_TRIG !== 4'h0 || b.O_BUSY !== 1'b0) begin nbad++; $display("FAIL nrdy%0d_after got trig=%b busy=%b exp 0000 0", i, b.O_TRIG, b.O_BUSY); end
      clr();
    end
  endtask
  task automatic test_out_of_order;
    arm(); fire();
    tick(); tick();
    gate(0);
    b.I_GATE[3] = 1'b1;
    tick();
    b.I_GATE[3] = 1'b0;
    nchk++;
    if (b.O_FCODE !== 2'd3 || b.O_OE !== 4'h0 || b.O_FAULT !== 1'b1 || b.O_TRIG !== 4'h0) begin
      nbad++; $display("FAIL ooo got fc=%0d oe=%b flt=%b trig=%b exp 3 0000 1 0000", b.O_FCODE, b.O_OE, b.O_FAULT, b.O_TRIG);
    end
    tick(); clr();
  endtask
  task automatic test_abort_reset;
    for (int k = 0; k < N; k++) wr(k, 1'b0, 24'($urandom), 1'b1);
    arm(); fire();
    tick(); gate(0); tick(); gate(1); tick(); tick();
    nchk++;
    if (b.O_STAGE !== 3'd2 || b.O_BUSY !== 1'b1) begin nbad++; $display("FAIL abrt_stage got stg=%0d busy=%b exp 2 1", b.O_STAGE, b.O_BUSY); end
    abort();
    nchk++;
    if (b.O_BUSY !== 1'b0 || b.O_OE !== 4'h0 || b.O_TRIG !== 4'h0 || b.O_LMT !== ml || b.O_DLY !== md) begin
      nbad++; $display("FAIL abrt got busy=%b oe=%b trig=%b lmt=%h exp 0 0000 0000 lmt=%h", b.O_BUSY, b.O_OE, b.O_TRIG, b.O_LMT, ml);
    end
    arm();
    rst = 1'b1; tick(); rst = 1'b0;
    ml = '0; md = '0;
    nchk++;
    if ({b.O_TRIG, b.O_OE, b.O_STAGE, b.O_BUSY, b.O_DONE, b.O_FAULT, b.O_FCODE} !== '0 || b.O_LMT !== ml || b.O_DLY !== md) begin
      nbad++; $display("FAIL rst_armed got oe=%b busy=%b stg=%0d lmt=%h dly=%h exp all zero", b.O_OE, b.O_BUSY, b.O_STAGE, b.O_LMT, b.O_DLY);
    end
  endtask
  task automatic test_write_lockout;
    wr(1, 1'b0, 24'h00ABCD, 1'b1);
    arm();
    wr(1, 1'b0, 24'($urandom), 1'b0);
    wr(2, 1'b1, 24'($urandom), 1'b0);
    nchk++;
    if (b.O_LMT !== ml || b.O_DLY !== md) begin nbad++; $display("FAIL lock_armed got lmt=%h dly=%h exp lmt=%h dly=%h", b.O_LMT, b.O_DLY, ml, md); end
    abort();
    wr(5, 1'b0, 24'($urandom), 1'b1);
    wr(7, 1'b1, 24'($urandom), 1'b1);
    nchk++;
    if (b.O_LMT !== ml || b.O_DLY !== md) begin nbad++; $display("FAIL lock_addr got lmt=%h dly=%h exp lmt=%h dly=%h", b.O_LMT, b.O_DLY, ml, md); end
    wr(N - 1, 1'b1, 24'($urandom), 1'b1);
    nchk++;
    if (b.O_DLY !== md) begin nbad++; $display("FAIL lock_last_addr got dly=%h exp dly=%h", b.O_DLY, md); end
  endtask
  task automatic test_arm_fire_same;
    b.I_ARM = 1'b1; b.I_FIRE = 1'b1;
    tick();
    b.I_ARM = 1'b0; b.I_FIRE = 1'b0;
    nchk++;
    if (b.O_BUSY !== 1'b1 || b.O_TRIG !== 4'h0) begin nbad++; $display("FAIL armfire got busy=%b trig=%b exp 1 0000", b.O_BUSY, b.O_TRIG); end
    tick();
    nchk++;
    if (b.O_TRIG !== 4'h0 || b.O_STAGE !== 3'd0) begin nbad++; $display("FAIL armfire_late got trig=%b exp 0000", b.O_TRIG); end
    fire();
    nchk++;
    if (b.O_TRIG !== 4'b0001) begin nbad++; $display("FAIL armfire_fire got trig=%b exp 0001", b.O_TRIG); end
    abort();
  endtask
  initial begin
    b.I_WE = 1'b0; b.I_WADDR = '0; b.I_WSEL = 1'b0; b.I_WDATA = '0;
    b.I_ARM = 1'b0; b.I_FIRE = 1'b0; b.I_ABORT = 1'b0; b.I_CLR = 1'b0;
    b.I_GATE = '0; b.I_RDY = '1;
    ml = '0; md = '0;
    test_reset();
    test_config_nominal();
    test_random_runs();
    test_timeout();
    test_timeout_tie();
    test_not_ready();
    test_out_of_order();
    test_abort_reset();
    test_write_lockout();
    test_arm_fire_same();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
